ising_lattice_reader: RTL
=========================

ISING_LATTICE_READER -- requirements
Module: ising_lattice_reader

Interface
REQ-001 SHALL have parameter N, default 8, lattice side length (rows = columns = N).
REQ-002 SHALL have parameter MAG_W, default 7, width of the up-spin count ($clog2(N*N)+1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request one snapshot-and-readout of the lattice.
REQ-006 SHALL have port lattice_in  input  N*N  live lattice; bit N*k+l = spin at row k, column l (1 = up).
REQ-007 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-008 SHALL have port row_valid  output  1  row_data/row_idx hold a valid row.
REQ-009 SHALL have port row_ready  input  1  consumer accepts the row when row_valid is high.
REQ-010 SHALL have port row_data  output  N  snapshot row; row_data[l] = spin (row_idx, l).
REQ-011 SHALL have port row_idx  output  $clog2(N)  index of the row on row_data.
REQ-012 SHALL have port mag  output  MAG_W  number of up spins in the last completed snapshot.
REQ-013 SHALL have port mag_valid  output  1  mag holds a completed result.
REQ-014 SHALL have port done  output  1  one-cycle pulse at completion of a readout.

Function
REQ-015 FSM states SHALL be IDLE, SEND, FINISH.
REQ-016 In IDLE, start=1 at a rising edge SHALL copy lattice_in into an internal snapshot register, clear the row counter and accumulator, clear mag_valid, and enter SEND.
REQ-017 Changes on lattice_in after the capture edge SHALL NOT affect row_data or mag of that readout.
REQ-018 In SEND, row_valid SHALL be 1 with row_data = snapshot row r and row_idx = r; first row (r=0) valid the cycle after capture.
REQ-019 A row SHALL transfer on a rising edge with row_valid=1 and row_ready=1; accumulator += popcount(row), r increments.
REQ-020 While row_valid=1 and row_ready=0, row_data and row_idx SHALL stay stable; no row is skipped or repeated.
REQ-021 Transfer of row N-1 SHALL move the FSM to FINISH; row_valid SHALL be 0 in FINISH.
REQ-022 In FINISH (exactly one cycle) done=1, mag = final accumulator, mag_valid=1; next state IDLE.
REQ-023 mag and mag_valid SHALL hold until the next accepted start or reset.
REQ-024 start while busy (SEND/FINISH) SHALL be ignored, with no effect on the readout in progress.
REQ-025 With row_ready held 1, start sampled at edge 0 SHALL give rows 0..N-1 in cycles 1..N and done in cycle N+1; start accepted again from cycle N+2.
REQ-026 Accumulator SHALL be MAG_W bits, unsaturated; all-up lattice yields N*N exactly.

Reset
REQ-027 reset=1 SHALL immediately (asynchronously) force IDLE, busy=0, row_valid=0, row_data=0, row_idx=0, mag=0, mag_valid=0, done=0, accumulator and snapshot cleared.
REQ-028 Reset during SEND or FINISH SHALL abort the readout with no done pulse; reset overrides a simultaneous start.

Structure
REQ-029 A shared package ising_pkg SHALL hold N default, MAG_W derivation, and the FSM state enum.
REQ-030 Row popcount SHALL be one sub-module, popcount_row (N-bit input, MAG_W-bit count, combinational).

Verification
REQ-031 All-ones lattice, row_ready=1, start pulse at cycle 0 -> row_data=0xFF for row_idx 0..7 in cycles 1..8, done=1 in cycle 9, mag=64, mag_valid=1.
REQ-032 Checkerboard lattice (rows alternating 0x55/0xAA) -> rows match in order, mag=32.
REQ-033 row_ready=0 for 3 cycles while row_idx=2 -> row_data/row_idx stable those cycles, row 3 only after row_ready returns; mag unchanged in correctness.
REQ-034 start re-pulsed at cycles 3 and 9 during a readout, lattice_in changed at cycle 2 -> both ignored, output rows equal cycle-0 snapshot, single done.
REQ-035 reset asserted while row_idx=4 -> row_valid, busy, mag_valid drop immediately, no done; a subsequent start on all-zero lattice -> mag=0, done after 9 cycles.

Source files
------------

// File: rtl/ising_pkg.sv
// Shared lattice-reader definitions: default lattice size, magnetisation width
// derivation and the readout FSM state encoding.
package ising_pkg;

    localparam int N_DEFAULT = 8;

    // Up-spin count of an N x N lattice needs to represent 0..N*N inclusive.
    function automatic int mag_width(input int n);
        return $clog2(n * n) + 1;
    endfunction

    localparam int MAG_W_DEFAULT = mag_width(N_DEFAULT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/popcount_row.sv
// Combinational population count of one lattice row.
module popcount_row #(
    parameter int N     = 8,
    parameter int MAG_W = 7
) (
    input  logic [N-1:0]     row,
    output logic [MAG_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + MAG_W'(row[i]);
        end
    end

endmodule

// File: rtl/ising_lattice_reader.sv
// Snapshots the live spin lattice on start, streams it out row by row with
// valid/ready handshaking and reports the total up-spin count at the end.
module ising_lattice_reader
    import ising_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int MAG_W = mag_width(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N*N-1:0]       lattice_in,
    output logic                 busy,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [N-1:0]         row_data,
    output logic [$clog2(N)-1:0] row_idx,
    output logic [MAG_W-1:0]     mag,
    output logic                 mag_valid,
    output logic                 done
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state_reg, state_next;
    logic [N*N-1:0]   snap_reg, snap_next;
    logic [IDX_W-1:0] row_reg, row_next;
    logic [MAG_W-1:0] acc_reg, acc_next;
    logic [MAG_W-1:0] mag_reg, mag_next;
    logic             mag_valid_reg, mag_valid_next;

    logic [N-1:0]     rows [N];
    logic [N-1:0]     cur_row;
    logic [MAG_W-1:0] row_count;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rows
            assign rows[gi] = snap_reg[gi*N +: N];
        end
    endgenerate

    assign cur_row = rows[row_reg];

    popcount_row #(
        .N     (N),
        .MAG_W (MAG_W)
    ) u_popcount (
        .row   (cur_row),
        .count (row_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            snap_reg      <= '0;
            row_reg       <= '0;
            acc_reg       <= '0;
            mag_reg       <= '0;
            mag_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            snap_reg      <= snap_next;
            row_reg       <= row_next;
            acc_reg       <= acc_next;
            mag_reg       <= mag_next;
            mag_valid_reg <= mag_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        snap_next      = snap_reg;
        row_next       = row_reg;
        acc_next       = acc_reg;
        mag_next       = mag_reg;
        mag_valid_next = mag_valid_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    snap_next      = lattice_in;
                    row_next       = '0;
                    acc_next       = '0;
                    mag_valid_next = 1'b0;
                    state_next     = SEND;
                end
            end
            SEND: begin
                if (row_ready) begin
                    acc_next = acc_reg + row_count;
                    if (row_reg == LAST_IDX) begin
                        // Publish the result here so it is already valid in the done cycle.
                        row_next       = '0;
                        mag_next       = acc_reg + row_count;
                        mag_valid_next = 1'b1;
                        state_next     = FINISH;
                    end else begin
                        row_next = row_reg + IDX_W'(1);
                    end
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign row_valid = (state_reg == SEND);
    assign row_data  = row_valid ? cur_row : '0;
    assign row_idx   = row_reg;
    assign mag       = mag_reg;
    assign mag_valid = mag_valid_reg;
    assign done      = (state_reg == FINISH);

endmodule
